time_trigger: RTL and testbench
===============================

TIME_TRIGGER -- requirements
Module: time_trigger

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning command queue depth in entries (power of two, 2..16).
REQ-002 SHALL have parameter LEN_W, default 16, meaning width of the gate duration field in time ticks.
REQ-003 SHALL have port clk  input  1  meaning single system clock; all logic on posedge clk.
REQ-004 SHALL have port rst  input  1  meaning asynchronous, active-high reset.
REQ-005 SHALL have port time_q  input  32  meaning free-running time counter from the upstream time counter, same clk domain.
REQ-006 SHALL have port clr  input  1  meaning synchronous flush of queue and active gate.
REQ-007 SHALL have port cmd_valid  input  1  meaning command present.
REQ-008 SHALL have port cmd_ready  output  1  meaning queue not full.
REQ-009 SHALL have port cmd_time  input  32  meaning target time value.
REQ-010 SHALL have port cmd_len  input  LEN_W  meaning gate length in ticks (0 means 1 tick).
REQ-011 SHALL have port gate  output  1  meaning high while the scheduled window is active.
REQ-012 SHALL have port start  output  1  meaning one-clk pulse on gate rise.
REQ-013 SHALL have port late  output  1  meaning one-clk pulse when a popped command's target has already passed.
REQ-014 SHALL have port busy  output  1  meaning queue non-empty or gate high.

Function
REQ-015 SHALL accept a command on a clk edge where cmd_valid and cmd_ready are both 1; cmd_time and cmd_len are captured together.
REQ-016 SHALL hold cmd_ready at 0 while the queue holds DEPTH entries; the queue is full when DEPTH entries are stored.
REQ-017 SHALL generate tick as a one-clk strobe when time_q differs from its value registered one clk earlier.
REQ-018 SHALL run an FSM with states IDLE, LOAD, WAIT, ACTIVE.
REQ-019 SHALL move IDLE->LOAD when the queue is non-empty, popping the head entry into the working registers.
REQ-020 SHALL, in LOAD, compute d = time_q - target as a 32-bit signed difference, which makes the comparison wrap-around safe.
REQ-021 SHALL move LOAD->WAIT when d<0, and SHALL move LOAD->ACTIVE when d>=0.
REQ-022 SHALL pulse late during the LOAD cycle when d>0.
REQ-023 SHALL move WAIT->ACTIVE on the first clk where time_q == target.
REQ-024 SHALL assert gate and pulse start on entry to ACTIVE, with latency of 1 clk from the match.
REQ-025 SHALL, in ACTIVE, decrement a LEN_W duration counter on each tick.
REQ-026 SHALL leave ACTIVE after max(cmd_len,1) ticks, deasserting gate on the same clk as the final tick.
REQ-027 SHALL go directly to LOAD when leaving ACTIVE with the queue non-empty, and SHALL go to IDLE when leaving ACTIVE with the queue empty.
REQ-028 SHALL, on a same-clk push and pop, perform both operations with the occupancy unchanged.
REQ-029 SHALL, when a push occurs while the queue is full, ignore the push because cmd_ready is 0.
REQ-030 SHALL, on clr, empty the queue, drop gate the next clk, return the FSM to IDLE and emit no pulses; clr has priority over a simultaneous push.
REQ-031 SHALL treat a time_q jump backwards (upstream clear) in WAIT as a normal compare, so the entry waits until equality.

Reset
REQ-032 SHALL, while rst=1, asynchronously force the FSM to IDLE, queue pointers and occupancy to 0, gate=0, start=0, late=0, busy=0, cmd_ready=0 and the registered time_q to 0.
REQ-033 SHALL raise cmd_ready on the first clk after rst deasserts.
REQ-034 SHALL abort an active gate immediately when rst asserts mid-operation.

Configuration
REQ-035 SHALL, with TIME_TRIGGER_STAT_EN defined, add output fired_cnt [15:0] (ACTIVE entries) and output late_cnt [15:0] (late pulses), both saturating at 16'hFFFF and cleared by rst or clr.
REQ-036 SHALL, without TIME_TRIGGER_STAT_EN defined, omit these ports and counters entirely.

Structure
REQ-037 SHALL place the FSM state encoding (IDLE=0, LOAD=1, WAIT=2, ACTIVE=3) and the TIME_W=32 constant in shared package time_pkg.
REQ-038 SHALL implement the queue as sub-module time_cmd_fifo (synchronous FIFO, width 32+LEN_W, depth DEPTH, push/pop/full/empty/count).

Verification
REQ-039 SHALL cover: push (time=100, len=3), time_q stepping +1 every 4 clk from 90 -> start once at time_q=100, gate high for exactly 3 ticks (12 clk), no late.
REQ-040 SHALL cover: push target 50 when time_q=60 -> late and start pulse in the same cycle, gate for 1 tick (len=0).
REQ-041 SHALL cover: push 4 commands (200,210,220,230) then a 5th -> cmd_ready=0 on the 5th, all 4 fire in order, cmd_ready returns after the first pop.
REQ-042 SHALL cover: target 32'h0000_0005 with time_q starting at 32'hFFFF_FFF0 -> WAIT across the wrap, fire at 5, no late.
REQ-043 SHALL cover: clr asserted mid-ACTIVE with 2 queued entries -> gate=0 next clk, busy=0, no further start pulses.
REQ-044 SHALL cover: rst asserted mid-WAIT -> all outputs 0 asynchronously; with TIME_TRIGGER_STAT_EN, fired_cnt=late_cnt=0.

Source files
------------

// File: rtl/time_pkg.sv
// +----------------------------------------------------------------------+
// | time_pkg : shared FSM encoding, time width and wrap-safe difference   |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package time_pkg;

  localparam int TIME_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    WAIT   = 2'd2,
    ACTIVE = 2'd3
  } state_e;

  // Signed modular difference: negative means the target is still ahead.
  function automatic logic signed [TIME_W-1:0] time_diff(
    input logic [TIME_W-1:0] now,
    input logic [TIME_W-1:0] target
  );
    return $signed(now - target);
  endfunction

endpackage

`default_nettype wire

// File: rtl/time_cmd_fifo.sv
// +----------------------------------------------------------------------+
// | time_cmd_fifo : synchronous first-word-fall-through command queue     |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module time_cmd_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full && !clr;
    do_pop   = pop && !empty && !clr;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/time_trigger.sv
// +----------------------------------------------------------------------+
// | time_trigger : queued time-scheduled gate generator                   |
// | Option   : TIME_TRIGGER_STAT_EN adds fired_cnt / late_cnt counters    |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module time_trigger
  import time_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LEN_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TIME_W-1:0] time_q,
  input  logic              clr,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [TIME_W-1:0] cmd_time,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              gate,
  output logic              start,
  output logic              late,
  output logic              busy
`ifdef TIME_TRIGGER_STAT_EN
  ,
  output logic [15:0]       fired_cnt,
  output logic [15:0]       late_cnt
`endif
);

  localparam int ENTRY_W = TIME_W + LEN_W;
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ENTRY_W-1:0] fifo_rdata;
  logic               fifo_full, fifo_empty;
  logic [AW:0]        fifo_count;
  logic               push, pop;

  state_e                   state_q, state_d;
  logic [TIME_W-1:0]        target_q, target_d;
  logic [LEN_W-1:0]         len_q, len_d;
  logic [LEN_W-1:0]         dur_q, dur_d;
  logic [TIME_W-1:0]        time_prev_q;
  logic                     ready_en_q;
  logic                     start_q, start_d;
  logic                     late_q, late_d;
  logic                     tick;
  logic signed [TIME_W-1:0] diff;
  logic [LEN_W-1:0]         first_dur;

  assign tick      = (time_q != time_prev_q);
  assign diff      = time_diff(time_q, target_q);
  assign first_dur = (len_q == '0) ? LEN_W'(1) : len_q;

  assign cmd_ready = ready_en_q && !fifo_full;
  assign push      = cmd_valid && cmd_ready && !clr;
  assign gate      = (state_q == ACTIVE);
  assign start     = start_q;
  assign late      = late_q;
  assign busy      = (fifo_count != '0) || gate;

  time_cmd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .wdata ({cmd_time, cmd_len}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    len_d    = len_q;
    dur_d    = dur_q;
    start_d  = 1'b0;
    late_d   = 1'b0;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (diff[TIME_W-1]) begin
          state_d = WAIT;
        end else begin
          state_d = ACTIVE;
          start_d = 1'b1;
          late_d  = (diff != '0);
          dur_d   = first_dur;
        end
      end
      WAIT: begin
        if (time_q == target_q) begin
          state_d = ACTIVE;
          start_d = 1'b1;
          dur_d   = first_dur;
        end
      end
      ACTIVE: begin
        if (tick) begin
          if (dur_q <= LEN_W'(1)) begin
            dur_d = '0;
            if (!fifo_empty) begin
              pop     = 1'b1;
              state_d = LOAD;
            end else begin
              state_d = IDLE;
            end
          end else begin
            dur_d = dur_q - 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (clr) begin
      state_d = IDLE;
      start_d = 1'b0;
      late_d  = 1'b0;
      pop     = 1'b0;
    end
    if (pop) begin
      target_d = fifo_rdata[ENTRY_W-1:LEN_W];
      len_d    = fifo_rdata[LEN_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      target_q    <= '0;
      len_q       <= '0;
      dur_q       <= '0;
      time_prev_q <= '0;
      ready_en_q  <= 1'b0;
      start_q     <= 1'b0;
      late_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      len_q       <= len_d;
      dur_q       <= dur_d;
      time_prev_q <= time_q;
      ready_en_q  <= 1'b1;
      start_q     <= start_d;
      late_q      <= late_d;
    end
  end

`ifdef TIME_TRIGGER_STAT_EN
  logic [15:0] fired_cnt_q, fired_cnt_d;
  logic [15:0] late_cnt_q, late_cnt_d;

  // start_d/late_d are already forced low by clr, so only the clear needs handling here.
  always_comb begin
    fired_cnt_d = fired_cnt_q;
    late_cnt_d  = late_cnt_q;
    if (clr) begin
      fired_cnt_d = '0;
      late_cnt_d  = '0;
    end else begin
      if (start_d && (fired_cnt_q != 16'hFFFF)) fired_cnt_d = fired_cnt_q + 16'd1;
      if (late_d && (late_cnt_q != 16'hFFFF))   late_cnt_d  = late_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fired_cnt_q <= '0;
      late_cnt_q  <= '0;
    end else begin
      fired_cnt_q <= fired_cnt_d;
      late_cnt_q  <= late_cnt_d;
    end
  end

  assign fired_cnt = fired_cnt_q;
  assign late_cnt  = late_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_time_trigger.sv
// +----------------------------------------------------------------------+
// | tb_time_trigger : directed self-checking bench for time_trigger       |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_time_trigger;

  localparam int DEPTH = 4;
  localparam int LEN_W = 16;

  logic             clk       = 1'b0;
  logic             rst       = 1'b1;
  logic             clr       = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [31:0]      time_q    = '0;
  logic [31:0]      cmd_time  = '0;
  logic [LEN_W-1:0] cmd_len   = '0;
  logic             cmd_ready, gate, start, late, busy;
`ifdef TIME_TRIGGER_STAT_EN
  logic [15:0]      fired_cnt, late_cnt;
`endif

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_start  = 0;
  int          n_late   = 0;
  int          n_gate   = 0;
  int          n_both   = 0;
  logic [31:0] st_time [8];

  always #5 clk = ~clk;

  time_trigger #(
    .DEPTH (DEPTH),
    .LEN_W (LEN_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .time_q    (time_q),
    .clr       (clr),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_time  (cmd_time),
    .cmd_len   (cmd_len),
    .gate      (gate),
    .start     (start),
    .late      (late),
    .busy      (busy)
`ifdef TIME_TRIGGER_STAT_EN
    ,
    .fired_cnt (fired_cnt),
    .late_cnt  (late_cnt)
`endif
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (gate) n_gate++;
      if (late) n_late++;
      if (start) begin
        if (n_start < 8) st_time[n_start] = time_q;
        n_start++;
        if (late) n_both++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    n_start = 0;
    n_late  = 0;
    n_gate  = 0;
    n_both  = 0;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    clr       = 1'b0;
    cmd_valid = 1'b0;
    clk1();
    clk1();
    rst = 1'b0;
    clk1();
    clear_mon();
  endtask

  task automatic push(input logic [31:0] t, input logic [LEN_W-1:0] l);
    cmd_time  = t;
    cmd_len   = l;
    cmd_valid = 1'b1;
    clk1();
    cmd_valid = 1'b0;
  endtask

  task automatic step(input int period, input int n);
    repeat (n) begin
      repeat (period) clk1();
      time_q = time_q + 32'd1;
    end
  endtask

  task automatic wait_gate(input string tag, input int bound);
    int k = 0;
    while (!gate && k < bound) begin
      clk1();
      k++;
    end
    check(tag, gate, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and cmd_ready release
    clk1();
    check("rst_gate", gate, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", cmd_ready, 0);
    check("rst_start", start, 0);
    clk1();
    rst = 1'b0;
    check("ready_pre", cmd_ready, 0);
    clk1();
    check("ready_post", cmd_ready, 1);

    // Basic fire: target 100, len 3, time steps every 4 clk from 90
    do_reset();
    time_q = 32'd90;
    clk1();
    push(32'd100, 16'd3);
    step(4, 17);
    check("t1_starts", n_start, 1);
    check("t1_st_time", st_time[0], 32'd100);
    check("t1_gate_clk", n_gate, 12);
    check("t1_late", n_late, 0);
    check("t1_busy_end", busy, 0);
`ifdef TIME_TRIGGER_STAT_EN
    check("t1_fired_cnt", fired_cnt, 1);
    check("t1_late_cnt", late_cnt, 0);
`endif

    // Late command: target 50 at time 60, len 0 lasts one tick
    do_reset();
    time_q = 32'd60;
    clk1();
    push(32'd50, 16'd0);
    wait_gate("t2_gate", 8);
    check("t2_start", start, 1);
    check("t2_late", late, 1);
    repeat (3) clk1();
    check("t2_hold", gate, 1);
    time_q = 32'd61;
    clk1();
    check("t2_end", gate, 0);
    check("t2_both", n_both, 1);
    check("t2_nlate", n_late, 1);
`ifdef TIME_TRIGGER_STAT_EN
    check("t2_fired_cnt", fired_cnt, 1);
    check("t2_late_cnt", late_cnt, 1);
`endif

    // Full queue: blocker holds ACTIVE while four commands fill the queue
    do_reset();
    time_q = 32'd190;
    clk1();
    push(32'd190, 16'd0);
    wait_gate("t3_blk", 8);
    push(32'd200, 16'd1);
    push(32'd210, 16'd1);
    push(32'd220, 16'd1);
    check("t3_ready_3", cmd_ready, 1);
    push(32'd230, 16'd1);
    check("t3_full", cmd_ready, 0);
    check("t3_busy", busy, 1);
    push(32'd240, 16'd1);
    check("t3_still_full", cmd_ready, 0);
    clear_mon();
    time_q = 32'd191;
    clk1();
    check("t3_ready_back", cmd_ready, 1);
    step(2, 50);
    check("t3_starts", n_start, 4);
    check("t3_order0", st_time[0], 32'd200);
    check("t3_order1", st_time[1], 32'd210);
    check("t3_order2", st_time[2], 32'd220);
    check("t3_order3", st_time[3], 32'd230);
    check("t3_late", n_late, 0);
    check("t3_busy_end", busy, 0);

    // Wrap-around wait
    do_reset();
    time_q = 32'hFFFF_FFF0;
    clk1();
    push(32'h0000_0005, 16'd0);
    step(2, 30);
    check("t4_starts", n_start, 1);
    check("t4_st_time", st_time[0], 32'h0000_0005);
    check("t4_late", n_late, 0);
    check("t4_gate_end", gate, 0);

    // clr mid-ACTIVE with two queued entries, racing a push
    do_reset();
    time_q = 32'd300;
    clk1();
    push(32'd300, 16'd0);
    wait_gate("t5_gate", 8);
    push(32'd400, 16'd0);
    push(32'd500, 16'd0);
    check("t5_busy", busy, 1);
    clr       = 1'b1;
    cmd_valid = 1'b1;
    cmd_time  = 32'd600;
    clk1();
    clr       = 1'b0;
    cmd_valid = 1'b0;
    check("t5_gate_off", gate, 0);
    check("t5_busy_off", busy, 0);
    check("t5_start", start, 0);
    clear_mon();
    step(1, 310);
    check("t5_no_start", n_start, 0);
`ifdef TIME_TRIGGER_STAT_EN
    check("t5_fired_cnt", fired_cnt, 0);
`endif

    // Asynchronous reset mid-WAIT and mid-ACTIVE
    do_reset();
    time_q = 32'd900;
    clk1();
    push(32'd890, 16'd0);
    wait_gate("t6_first", 8);
    time_q = 32'd901;
    clk1();
    push(32'd1000, 16'd0);
    repeat (4) clk1();
`ifdef TIME_TRIGGER_STAT_EN
    check("t6_fired_pre", fired_cnt, 1);
`endif
    #3 rst = 1'b1;
    #1;
    check("t6_w_gate", gate, 0);
    check("t6_w_busy", busy, 0);
    check("t6_w_ready", cmd_ready, 0);
    check("t6_w_late", late, 0);
`ifdef TIME_TRIGGER_STAT_EN
    check("t6_fired_cnt", fired_cnt, 0);
    check("t6_late_cnt", late_cnt, 0);
`endif
    clk1();
    rst = 1'b0;
    clk1();
    push(32'd901, 16'd0);
    wait_gate("t6_active", 8);
    #3 rst = 1'b1;
    #1;
    check("t6_abort", gate, 0);
    check("t6_a_start", start, 0);
    clk1();
    rst = 1'b0;
    clk1();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
